// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM scheduler slice.
package pwm_pkg;

    // Default channel count, counter/duty width and prescaler width.
    localparam int DEF_NCH = 4;
    localparam int DEF_CW  = 3;
    localparam int DEF_PW  = 4;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_sched_if.sv
// Duty-write handshake between a host and the PWM scheduler.
interface pwm_sched_if
    import pwm_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = DEF_CW
);
    localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pwm_presc.sv
// Prescaler: one tick every presc+1 enabled clocks, held cleared while disabled.
module pwm_presc #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] presc,
    output logic          tick
);
    logic [PW-1:0] pcnt;

    // Comparing against the live presc value lets a new divide take effect on the next compare.
    assign tick = en && (pcnt >= presc);

    // Count up between ticks; restart from zero on tick, reset or disable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst || !en) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_sched.sv
// PWM period scheduler: shared trigger counter plus double-buffered per-channel duties.
module pwm_sched
    import pwm_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = DEF_CW,
    parameter int PW  = DEF_PW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [PW-1:0]     presc,
    pwm_sched_if.slave        wr,
    output logic [CW-1:0]     trigger,
    output logic [NCH*CW-1:0] dc_bus,
    output logic              period_start,
    output logic              busy
);
    state_t        state;
    state_t        state_nxt;
    logic          tick;
    logic          wrap;
    logic          commit;
    logic [CW-1:0] pending [NCH];
    logic [CW-1:0] active  [NCH];

    pwm_presc #(.PW(PW)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (state != ST_IDLE),
        .presc (presc),
        .tick  (tick)
    );

    assign wrap   = tick && (trigger == {CW{1'b1}});
    assign commit = (state == ST_IDLE && run) || (state == ST_RUN && wrap && run);

    // Writes are held off only on commit edges so pending never changes while being copied.
    assign wr.wr_ready = !commit;

    // Next-state decode for the IDLE/RUN/DRAIN controller.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (run) state_nxt = ST_RUN;
            ST_RUN: begin
                if (wrap)      state_nxt = run ? ST_RUN : ST_IDLE;
                else if (!run) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wrap)     state_nxt = ST_IDLE;
                else if (run) state_nxt = ST_RUN;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Controller state, shared period counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            trigger      <= '0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            period_start <= commit;
            busy         <= (state_nxt != ST_IDLE);
            if (state == ST_IDLE) begin
                trigger <= '0;
            end else if (tick) begin
                trigger <= trigger + 1'b1;
            end
        end
    end

    // Pending duties take host writes; active duties load from pending on commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the duty arrays are a few flops, so they are reset explicitly to drop pending writes.
            for (int i = 0; i < NCH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (wr.wr_valid && wr.wr_ready && (int'(wr.wr_addr) < NCH)) begin
                pending[wr.wr_addr] <= wr.wr_data;
            end
            if (commit) begin
                for (int i = 0; i < NCH; i++) begin
                    active[i] <= pending[i];
                end
            end
        end
    end

    // Registered duty bus: mirrors the active duties while counting, zero in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dc_bus <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (state_nxt == ST_IDLE) begin
                    dc_bus[i*CW +: CW] <= '0;
                end else if (commit) begin
                    dc_bus[i*CW +: CW] <= pending[i];
                end else begin
                    dc_bus[i*CW +: CW] <= active[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_sched.sv
// Randomized self-checking bench for pwm_sched against a period-arithmetic reference model.
module tb_pwm_sched;
    localparam int NCH   = 3;
    localparam int CW    = 3;
    localparam int PW    = 4;
    localparam int AW    = 2;
    localparam int STEPS = 1 << CW;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic              clk;
    logic              rst;
    logic              run;
    logic [PW-1:0]     presc;
    logic [CW-1:0]     trigger;
    logic [NCH*CW-1:0] dc_bus;
    logic              period_start;
    logic              busy;

    pwm_sched_if #(.NCH(NCH), .CW(CW)) bus ();

    pwm_sched #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .presc        (presc),
        .wr           (bus),
        .trigger      (trigger),
        .dc_bus       (dc_bus),
        .period_start (period_start),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode, clocks elapsed in the current period, duty buffers.
    int            m_mode = M_IDLE;
    int            m_el   = 0;
    bit            m_ps   = 1'b0;
    logic [CW-1:0] m_pend [NCH];
    logic [CW-1:0] m_act  [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int period_len();
        return STEPS * (int'(presc) + 1);
    endfunction

    function automatic int m_trig();
        return (m_mode == M_IDLE) ? 0 : (m_el / (int'(presc) + 1));
    endfunction

    function automatic bit m_commit();
        return (m_mode == M_IDLE && run) ||
               (m_mode == M_RUN && m_el == period_len() - 1 && run);
    endfunction

    function automatic logic [NCH*CW-1:0] m_dc();
        logic [NCH*CW-1:0] v;
        v = '0;
        if (m_mode != M_IDLE)
            for (int i = 0; i < NCH; i++) v[i*CW +: CW] = m_act[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_edge();
        bit c;
        bit wr_ok;
        c     = m_commit();
        wr_ok = bus.wr_valid && !c && (int'(bus.wr_addr) < NCH);
        if (!rst) begin
            m_mode = M_IDLE;
            m_el   = 0;
            m_ps   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = '0;
                m_act[i]  = '0;
            end
        end else begin
            if (c) for (int i = 0; i < NCH; i++) m_act[i] = m_pend[i];
            m_ps = c;
            if (m_mode == M_IDLE) begin
                if (run) begin
                    m_mode = M_RUN;
                    m_el   = 0;
                end
            end else if (m_el == period_len() - 1) begin
                m_el = 0;
                if (!c) m_mode = M_IDLE;
            end else begin
                m_el++;
                m_mode = run ? M_RUN : M_DRAIN;
            end
            if (wr_ok) m_pend[bus.wr_addr] = bus.wr_data;
        end
    endtask

    // Drive one cycle of inputs, check wr_ready before the edge and all outputs after it.
    task automatic step(input bit r, input bit rn, input bit v, input int a, input int d);
        rst          = r;
        run          = rn;
        bus.wr_valid = v;
        bus.wr_addr  = a[AW-1:0];
        bus.wr_data  = d[CW-1:0];
        #2;
        check("wr_ready", 32'(bus.wr_ready), 32'(!m_commit()));
        @(posedge clk);
        model_edge();
        #1;
        check("trigger", 32'(trigger), 32'(m_trig()));
        check("dc_bus", 32'(dc_bus), 32'(m_dc()));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("busy", 32'(busy), 32'(m_mode != M_IDLE));
    endtask

    task automatic wait_trig(input int t, input bit rn);
        for (int i = 0; i < 400; i++) begin
            if (m_mode != M_IDLE && m_trig() == t) break;
            step(1'b1, rn, 1'b0, 0, 0);
        end
    endtask

    task automatic go_idle();
        for (int i = 0; i < 400; i++) begin
            if (m_mode == M_IDLE) break;
            step(1'b1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    int ps_cnt;
    int ps_first;
    int ps_second;
    int low_cnt;
    bit r_run;

    initial begin
        rst = 1'b0; run = 1'b0; presc = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = '0;
            m_act[i]  = '0;
        end
        @(posedge clk); #1;

        // Reset state.
        repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_dc_bus", 32'(dc_bus), 32'd0);

        // presc=0, ch0=3, then run: one trigger step per clock.
        presc = 4'd0;
        step(1'b1, 1'b0, 1'b1, 0, 3);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        check("start_pulse", 32'(period_start), 32'd1);
        check("start_ch0", 32'(dc_bus[2:0]), 32'd3);
        for (int k = 1; k < STEPS; k++) begin
            step(1'b1, 1'b1, 1'b0, 0, 0);
            check("trig_seq", 32'(trigger), 32'(k));
        end

        // Mid-period write ch1=5 at trigger 4 commits at the next wrap.
        wait_trig(4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1, 5);
        wait_trig(0, 1'b1);
        check("ch1_commit", 32'(dc_bus[5:3]), 32'd5);
        repeat (4) step(1'b1, 1'b1, 1'b0, 0, 0);

        // Hold wr_valid across a wrap: ready low for just the commit cycle.
        wait_trig(7, 1'b1);
        low_cnt = 0;
        for (int k = 0; k < STEPS; k++) begin
            step(1'b1, 1'b1, 1'b1, 2, 6);
            if (!period_start && k == 0) low_cnt = low_cnt + 100;
            if (k == 0) low_cnt++;
        end
        check("commit_pulse_seen", 32'(low_cnt), 32'd1);
        check("ch2_not_yet", 32'(dc_bus[8:6]), 32'd0);
        wait_trig(0, 1'b1);
        check("ch2_commit", 32'(dc_bus[8:6]), 32'd6);

        // presc=2: trigger steps every 3 clocks, period_start every 24.
        go_idle();
        presc = 4'd2;
        ps_cnt = 0; ps_first = -1; ps_second = -1;
        for (int k = 0; k < 60; k++) begin
            step(1'b1, 1'b1, 1'b0, 0, 0);
            if (period_start) begin
                ps_cnt++;
                if (ps_first < 0) ps_first = k;
                else if (ps_second < 0) ps_second = k;
            end
        end
        check("ps_count", 32'(ps_cnt), 32'd3);
        check("ps_gap", 32'(ps_second - ps_first), 32'd24);

        // Drain at trigger 3 down to IDLE, then a drain cancelled at trigger 5.
        go_idle();
        presc = 4'd0;
        wait_trig(3, 1'b1);
        go_idle();
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_dc", 32'(dc_bus), 32'd0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        wait_trig(3, 1'b1);
        wait_trig(5, 1'b0);
        check("drain_trig5", 32'(trigger), 32'd5);
        wait_trig(0, 1'b1);
        check("redrive_pulse", 32'(period_start), 32'd1);

        // Reset at trigger 6 aborts the period and drops pending writes.
        step(1'b1, 1'b1, 1'b1, 0, 7);
        wait_trig(6, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        check("abort_trig", 32'(trigger), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 0, 0);
        check("abort_pending", 32'(dc_bus), 32'd0);

        // Randomized traffic: run toggles, writes incl. out-of-range, occasional reset.
        r_run = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 19) == 0) r_run = !r_run;
            if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) presc = 4'($urandom_range(0, 3));
            step($urandom_range(0, 299) != 0, r_run, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
